// File: rtl/neopixel_pattern_gen_if.sv
// Pattern-generator bus: transmitter handshake, rotation controls, palette port, slot outputs.
interface neopixel_pattern_gen_if;
    logic        rd_next;
    logic        step;
    logic        dir;
    logic        hold;
    logic [1:0]  bright;
    logic        pal_we;
    logic [4:0]  pal_addr;
    logic [23:0] pal_wdata;
    logic [23:0] pix_data;
    logic        msg_typ;
    logic        frame_done;

    modport master (
        output rd_next, step, dir, hold, bright, pal_we, pal_addr, pal_wdata,
        input  pix_data, msg_typ, frame_done
    );

    modport slave (
        input  rd_next, step, dir, hold, bright, pal_we, pal_addr, pal_wdata,
        output pix_data, msg_typ, frame_done
    );
endinterface

// File: rtl/neopixel_pattern_gen.sv
// NeoPixel colour-pattern source: writable palette, rotating pixel mapping, per-slot framing.
module neopixel_pattern_gen #(
    parameter int unsigned NUM_PIXELS   = 18,
    parameter int unsigned PALETTE_SIZE = 6,
    parameter int unsigned LATCH_SLOTS  = 2,
    parameter logic [PALETTE_SIZE*24-1:0] PAL_INIT = {24'h330033, 24'h000066, 24'h003333,
                                                      24'h006600, 24'h333300, 24'h660000}
) (
    input  logic                  clk,
    input  logic                  rst,
    neopixel_pattern_gen_if.slave bus
);
    localparam int unsigned TOTAL_SLOTS = NUM_PIXELS + LATCH_SLOTS;
    localparam int unsigned SLOT_W      = $clog2(TOTAL_SLOTS);
    localparam int unsigned PAL_W       = $clog2(PALETTE_SIZE);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(TOTAL_SLOTS - 1);
    localparam logic [PAL_W-1:0]  LAST_IDX  = PAL_W'(PALETTE_SIZE - 1);

    logic [23:0]       r_pal [PALETTE_SIZE];
    logic [SLOT_W-1:0] r_slot, w_slot_nxt;
    logic [PAL_W-1:0]  r_ofs, w_ofs_nxt;
    logic [PAL_W-1:0]  r_cidx, w_cidx_nxt;
    logic              r_pend, w_pend_nxt;
    logic [23:0]       r_pix_data, w_pix_nxt;
    logic              r_msg_typ, w_msg_nxt;
    logic              r_frame_done, w_done_nxt;

    logic              w_boundary;
    logic              w_apply;
    logic [PAL_W-1:0]  w_ofs_stepped;
    logic [PAL_W-1:0]  w_cidx_inc;
    logic              w_next_is_pixel;
    logic              w_wr_in_range;

    // Per-channel brightness: each GRB byte shifted right independently.
    function automatic logic [23:0] f_scale(input logic [23:0] c, input logic [1:0] b);
        return {c[23:16] >> b, c[15:8] >> b, c[7:0] >> b};
    endfunction

    assign w_boundary      = bus.rd_next && (r_slot == LAST_SLOT);
    assign w_apply         = w_boundary && !bus.hold && (r_pend || bus.step);
    assign w_ofs_stepped   = bus.dir ? ((r_ofs == '0) ? LAST_IDX : PAL_W'(r_ofs - PAL_W'(1)))
                                     : ((r_ofs == LAST_IDX) ? '0 : PAL_W'(r_ofs + PAL_W'(1)));
    assign w_cidx_inc      = (r_cidx == LAST_IDX) ? '0 : PAL_W'(r_cidx + PAL_W'(1));
    assign w_next_is_pixel = 32'(r_slot) < (NUM_PIXELS - 1);
    assign w_wr_in_range   = {27'd0, bus.pal_addr} < PALETTE_SIZE;

    // Next slot, rotation and output values; implicit PIXEL/LATCH state lives in r_slot.
    always_comb begin
        w_slot_nxt = r_slot;
        w_ofs_nxt  = r_ofs;
        w_cidx_nxt = r_cidx;
        w_pend_nxt = r_pend || bus.step;
        w_pix_nxt  = r_pix_data;
        w_msg_nxt  = r_msg_typ;
        w_done_nxt = 1'b0;

        if (w_boundary && !bus.hold) begin
            w_pend_nxt = 1'b0;
        end
        if (w_apply) begin
            w_ofs_nxt = w_ofs_stepped;
        end

        if (bus.rd_next) begin
            if (w_boundary) begin
                w_slot_nxt = '0;
                w_cidx_nxt = w_ofs_nxt;
                w_pix_nxt  = f_scale(r_pal[w_ofs_nxt], bus.bright);
                w_msg_nxt  = 1'b1;
                w_done_nxt = 1'b1;
            end else if (w_next_is_pixel) begin
                w_slot_nxt = SLOT_W'(r_slot + SLOT_W'(1));
                w_cidx_nxt = w_cidx_inc;
                w_pix_nxt  = f_scale(r_pal[w_cidx_inc], bus.bright);
                w_msg_nxt  = 1'b1;
            end else begin
                w_slot_nxt = SLOT_W'(r_slot + SLOT_W'(1));
                w_pix_nxt  = '0;
                w_msg_nxt  = 1'b0;
            end
        end
    end

    // Slot, rotation and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot       <= '0;
            r_ofs        <= '0;
            r_cidx       <= '0;
            r_pend       <= 1'b0;
            r_pix_data   <= PAL_INIT[23:0];
            r_msg_typ    <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_slot       <= w_slot_nxt;
            r_ofs        <= w_ofs_nxt;
            r_cidx       <= w_cidx_nxt;
            r_pend       <= w_pend_nxt;
            r_pix_data   <= w_pix_nxt;
            r_msg_typ    <= w_msg_nxt;
            r_frame_done <= w_done_nxt;
        end
    end

    // Palette storage; reads in the write cycle see the old entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(PALETTE_SIZE); i++) begin
                r_pal[i] <= PAL_INIT[i*24 +: 24];
            end
        end else if (bus.pal_we && w_wr_in_range) begin
            r_pal[bus.pal_addr[PAL_W-1:0]] <= bus.pal_wdata;
        end
    end

    assign bus.pix_data   = r_pix_data;
    assign bus.msg_typ    = r_msg_typ;
    assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_neopixel_pattern_gen.sv
// Scoreboard bench for neopixel_pattern_gen: driver queues expected slot outputs, monitor compares.
module tb_neopixel_pattern_gen;
    localparam int NP    = 18;
    localparam int TOTAL = 20;
    localparam int PS    = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    neopixel_pattern_gen_if bus();

    neopixel_pattern_gen dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    logic [25:0] exp_q[$];
    logic [23:0] tb_pal [PS];
    logic [4:0]  wr_addr_tab [32];
    logic [23:0] wr_data_tab [32];
    int  checks = 0;
    int  passes = 0;
    bit  fire = 1'b0;
    bit  started = 1'b0;
    bit  end_req = 1'b0;
    bit  end_done = 1'b0;

    task automatic restore_pal();
        tb_pal[0] = 24'h660000; tb_pal[1] = 24'h333300; tb_pal[2] = 24'h006600;
        tb_pal[3] = 24'h003333; tb_pal[4] = 24'h000066; tb_pal[5] = 24'h330033;
    endtask

    function automatic logic [23:0] exp_pix(input int p, input int o);
        logic [23:0] c;
        c = tb_pal[(p + o) % PS];
        return {c[23:16] >> bus.bright, c[15:8] >> bus.bright, c[7:0] >> bus.bright};
    endfunction

    task automatic push_exp(input logic [23:0] p, input logic m, input logic d);
        exp_q.push_back({p, m, d});
    endtask

    // n reset cycles; rd_during exercises rd_next being ignored under reset.
    task automatic do_reset(input int n, input logic rd_during);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = 1'b1; bus.rd_next = rd_during; bus.step = 1'b0; bus.pal_we = 1'b0;
            push_exp(24'h660000, 1'b1, 1'b0);
        end
        restore_pal();
        @(negedge clk);
        rst = 1'b0; bus.rd_next = 1'b0;
        started = 1'b1;
    endtask

    task automatic idle_write(input logic [4:0] a, input logic [23:0] d);
        @(negedge clk);
        bus.rd_next = 1'b0; bus.pal_we = 1'b1; bus.pal_addr = a; bus.pal_wdata = d;
        if (int'(a) < PS) tb_pal[a] = d;
        @(negedge clk);
        bus.pal_we = 1'b0;
    endtask

    // Issue rd_next pulses 1..n back to back from slot 0; ofs values are hand-chosen per test.
    task automatic run_frame(input int ofs_cur, input int ofs_next, input int n,
                             input logic [31:0] step_mask, input logic [31:0] wr_mask);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            bus.rd_next   = 1'b1;
            bus.step      = step_mask[k];
            bus.pal_we    = wr_mask[k];
            bus.pal_addr  = wr_addr_tab[k];
            bus.pal_wdata = wr_data_tab[k];
            if (k == TOTAL)   push_exp(exp_pix(0, ofs_next), 1'b1, 1'b1);
            else if (k < NP)  push_exp(exp_pix(k, ofs_cur), 1'b1, 1'b0);
            else              push_exp(24'h000000, 1'b0, 1'b0);
            if (wr_mask[k] && int'(wr_addr_tab[k]) < PS) tb_pal[wr_addr_tab[k]] = wr_data_tab[k];
        end
        @(negedge clk);
        bus.rd_next = 1'b0; bus.step = 1'b0; bus.pal_we = 1'b0;
    endtask

    // Marks cycles whose outputs the DUT has just (re)loaded.
    always @(posedge clk) fire <= (bus.rd_next === 1'b1) || (rst === 1'b1);

    // Monitor: compare loaded outputs against the scoreboard; idle cycles must not pulse frame_done.
    always @(negedge clk) begin
        logic [25:0] got, exp;
        got = {bus.pix_data, bus.msg_typ, bus.frame_done};
        if (fire) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL scoreboard_empty: got pix=%h msg=%b done=%b, required a queued expectation",
                         got[25:2], got[1], got[0]);
            end else begin
                exp = exp_q.pop_front();
                if (got === exp) passes++;
                else $display("FAIL slot_out @%0t: got pix=%h msg=%b done=%b, required pix=%h msg=%b done=%b",
                              $time, got[25:2], got[1], got[0], exp[25:2], exp[1], exp[0]);
            end
        end else if (started) begin
            checks++;
            if (bus.frame_done === 1'b0) passes++;
            else $display("FAIL idle_frame_done @%0t: got %b, required 0", $time, bus.frame_done);
        end
        if (end_req && !end_done) begin
            checks++;
            if (exp_q.size() == 0) passes++;
            else $display("FAIL scoreboard_leftover: got %0d entries, required 0", exp_q.size());
            end_done = 1'b1;
        end
    end

    initial begin
        bus.rd_next = 1'b0; bus.step = 1'b0; bus.dir = 1'b0; bus.hold = 1'b0;
        bus.bright = 2'd0; bus.pal_we = 1'b0; bus.pal_addr = '0; bus.pal_wdata = '0;
        for (int i = 0; i < 32; i++) begin wr_addr_tab[i] = '0; wr_data_tab[i] = '0; end
        restore_pal();
        repeat (2) @(negedge clk);

        // Reset (rd_next held high, must be ignored) and base frame.
        do_reset(2, 1'b1);
        run_frame(0, 0, TOTAL, 32'h0, 32'h0);

        // Forward rotation: six single steps bring the pattern back.
        for (int r = 0; r < 6; r++) run_frame(r, (r + 1) % PS, TOTAL, 32'h1 << 6, 32'h0);
        run_frame(0, 0, TOTAL, 32'h0, 32'h0);

        // Backward rotation with wrap, collapsed multi-step, step on the boundary itself.
        do_reset(1, 1'b0);
        bus.dir = 1'b1;
        run_frame(0, 5, TOTAL, 32'h1 << 3, 32'h0);
        run_frame(5, 4, TOTAL, (32'h1 << 2) | (32'h1 << 7) | (32'h1 << 11), 32'h0);
        run_frame(4, 3, TOTAL, 32'h1 << 20, 32'h0);

        // Hold defers a pending step to the next boundary.
        bus.dir = 1'b0; bus.hold = 1'b1;
        run_frame(3, 3, TOTAL, 32'h1 << 4, 32'h0);
        bus.hold = 1'b0;
        run_frame(3, 4, TOTAL, 32'h0, 32'h0);
        run_frame(4, 4, TOTAL, 32'h0, 32'h0);

        // Brightness and palette writes: same-cycle old value, out-of-range ignored.
        idle_write(5'd0, 24'hFF8040);
        bus.bright = 2'd2;
        wr_addr_tab[5] = 5'd3; wr_data_tab[5] = 24'h123456;
        wr_addr_tab[8] = 5'd7; wr_data_tab[8] = 24'hABCDEF;
        wr_addr_tab[9] = 5'd9; wr_data_tab[9] = 24'hABCDEF;
        run_frame(4, 4, TOTAL, 32'h0, (32'h1 << 5) | (32'h1 << 8) | (32'h1 << 9));
        run_frame(4, 4, TOTAL, 32'h0, 32'h0);
        bus.bright = 2'd0;

        // Reset at slot 9 with a step pending: pattern, offset and palette restored.
        run_frame(4, 4, 9, 32'h1 << 3, 32'h0);
        do_reset(1, 1'b0);
        run_frame(0, 0, TOTAL, 32'h0, 32'h0);

        repeat (2) @(negedge clk);
        end_req = 1'b1;
        for (int i = 0; i < 10 && !end_done; i++) @(negedge clk);
        if (!end_done) begin
            $display("FAIL end_timeout: got no final check, required one within 10 cycles");
            $fatal(1, "monitor did not respond");
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
